// File: rtl/pc_fetch_ctrl.sv
`timescale 1ns/1ps
// Fetch-stage sequencer: owns the PC register controls, runs the imem req/ack
// handshake, fills IF/ID through a one-deep skid buffer and drops stale fetches.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_ce,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FLUSH} state_t;

  state_t      state_reg;
  logic [31:0] req_addr_reg;
  logic [31:0] skid_instr_reg;
  logic [31:0] skid_pc_reg;

  logic        redir;
  logic [31:0] redir_target;
  logic        fetch_ack;
  logic [31:0] pc_inc;

  always_comb begin
    redir = exc_req | eret_req | redirect_valid;
    if (exc_req)
      redir_target = EXC_VECTOR;
    else if (eret_req)
      redir_target = epc;
    else
      redir_target = redirect_target;
  end

  assign fetch_ack = (state_reg == FETCH) && imem_ack;
  assign pc_inc    = pc_q + 32'd4;

  // FLUSH keeps presenting the abandoned address until the memory answers it.
  assign imem_req  = (state_reg == FETCH) || (state_reg == FLUSH);
  assign imem_addr = (state_reg == FLUSH) ? req_addr_reg : pc_q;
  assign pc_ce     = redir || fetch_ack;

  always_comb begin
    if (redir)
      pc_d = redir_target;
    else if (fetch_ack)
      pc_d = pc_inc;
    else
      pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= BOOT;
      if_valid       <= 1'b0;
      if_instr       <= 32'd0;
      if_pc          <= RESET_VECTOR;
      skid_instr_reg <= 32'd0;
      skid_pc_reg    <= RESET_VECTOR;
      req_addr_reg   <= RESET_VECTOR;
    end else if (redir) begin
      if_valid <= 1'b0;
      if (state_reg == FETCH && !imem_ack) begin
        req_addr_reg <= pc_q;
        state_reg    <= FLUSH;
      end else if (state_reg == FLUSH && !imem_ack) begin
        state_reg <= FLUSH;
      end else begin
        state_reg <= FETCH;
      end
    end else begin
      case (state_reg)
        BOOT: state_reg <= FETCH;
        FETCH: begin
          if (imem_ack && !stall) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc_q;
          end else if (imem_ack) begin
            skid_instr_reg <= imem_rdata;
            skid_pc_reg    <= pc_q;
            state_reg      <= HOLD;
          end else if (!stall) begin
            // Consumed by ID with nothing new behind it: leave a bubble.
            if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid  <= 1'b1;
            if_instr  <= skid_instr_reg;
            if_pc     <= skid_pc_reg;
            state_reg <= FETCH;
          end
        end
        FLUSH: begin
          if (imem_ack)
            state_reg <= FETCH;
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for pc_fetch_ctrl: external PC register, variable
// latency instruction memory, expected fetch stream kept as a queue of PCs.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] EV = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, exc_req = 1'b0, eret_req = 1'b0, redirect_valid = 1'b0;
  logic [31:0] epc = 32'd0, redirect_target = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc_q, pc_d, imem_addr, if_pc, if_instr;
  logic        pc_ce, imem_req, if_valid;

  int total = 0;
  int bad = 0;
  int consumed = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] last_pushed = RV;
  logic [31:0] mon_exp;
  bit          pend_redir = 1'b0;
  logic [31:0] pend_target = 32'd0;

  bit          mem_busy = 1'b0;
  int          mem_lat = 0;
  int          force_lat = -1;
  logic [31:0] mem_addr = 32'd0;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_q(pc_q), .pc_d(pc_d), .pc_ce(pc_ce), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RV;
    else if (pc_ce) pc_q <= pc_d;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == RV) return 32'h24080001;
    if (a == RV + 32'd4) return 32'h8C090000;
    return {a[15:0], a[31:16]} ^ 32'h5A5AA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Memory: each accepted request is answered after a random latency.
  task automatic mem_drive();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end else begin
        check("addr_stable", imem_addr, mem_addr);
      end
      if (mem_lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_data(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        mem_lat--;
      end
    end
  endtask

  // One cycle: drive inputs, cross the edge, then update the expected stream.
  task automatic step(input bit st, input bit ex, input bit er, input logic [31:0] ep,
                      input bit rv, input logic [31:0] rt);
    mem_drive();
    stall = st; exc_req = ex; eret_req = er; epc = ep;
    redirect_valid = rv; redirect_target = rt;
    pend_redir  = ex | er | rv;
    pend_target = ex ? EV : (er ? ep : rt);
    @(posedge clk);
    #1;
    if (pend_redir) begin
      exp_q.delete();
      exp_q.push_back(pend_target);
      last_pushed = pend_target;
      pend_redir = 1'b0;
    end
    while (exp_q.size() < 4) begin
      last_pushed = last_pushed + 32'd4;
      exp_q.push_back(last_pushed);
    end
  endtask

  task automatic reset_model();
    mon_en = 1'b0;
    stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; redirect_valid = 1'b0;
    imem_ack = 1'b0; mem_busy = 1'b0; pend_redir = 1'b0;
    exp_q.delete();
    exp_q.push_back(RV);
    last_pushed = RV;
  endtask

  // ID consumes the IF/ID contents on every unstalled edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!pc_ce) check("pc_d_idle", pc_d, pc_q);
      if (if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got pc %08h expected none", if_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          check("if_pc", if_pc, mon_exp);
          check("if_instr", if_instr, mem_data(mon_exp));
          consumed++;
          $display("deliver pc=%08h instr=%08h", if_pc, if_instr);
        end
      end
    end
  end

  initial begin
    reset_model();
    #1 rst = 1'b1;
    #2;
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, RV);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc_ce", {31'd0, pc_ce}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait sequential fetch, then a stall arriving with the second ack.
    force_lat = 0;
    step(0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RV);
    step(0, 0, 0, 0, 0, 0);
    check("first_valid", {31'd0, if_valid}, 32'd1);
    check("first_pc", if_pc, RV);
    check("first_instr", if_instr, 32'h24080001);
    check("pc_step1", pc_q, RV + 32'd4);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      check("stall_pc", if_pc, RV);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_pcq", pc_q, RV + 32'd8);
    end
    step(0, 0, 0, 0, 0, 0);
    check("skid_pc", if_pc, RV + 32'd4);
    check("skid_instr", if_instr, 32'h8C090000);
    step(0, 0, 0, 0, 0, 0);

    // Redirect while a slow fetch is outstanding.
    force_lat = 3;
    step(0, 0, 0, 0, 1, 32'hBFC00100);
    check("flush_pcq", pc_q, 32'hBFC00100);
    check("flush_addr", imem_addr, RV + 32'd12);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    check("flush_done_addr", imem_addr, 32'hBFC00100);
    check("flush_done_valid", {31'd0, if_valid}, 32'd0);

    // Priority with stall, then ERET alone.
    force_lat = 0;
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h80001000, 1, 32'h00400000);
    check("prio_pcq", pc_q, EV);
    check("prio_valid", {31'd0, if_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h80001000, 0, 0);
    check("eret_addr", imem_addr, 32'h80001000);

    // Wrap past the top of the address space.
    step(0, 0, 0, 0, 1, 32'hFFFFFFFC);
    step(0, 0, 0, 0, 0, 0);
    check("wrap_if_pc", if_pc, 32'hFFFFFFFC);
    check("wrap_addr", imem_addr, 32'h00000000);
    step(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a flush, followed by a late ack.
    force_lat = 3;
    step(0, 0, 0, 0, 1, 32'hBFC00200);
    step(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    reset_model();
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_if_pc", if_pc, RV);
    @(posedge clk);
    #1;
    imem_ack = 1'b1;
    imem_rdata = 32'h0BADF00D;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("late_ack_valid", {31'd0, if_valid}, 32'd0);
    check("restart_addr", imem_addr, RV);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    mon_en = 1'b1;

    // Randomized traffic.
    force_lat = -1;
    for (int i = 0; i < 1500; i++) begin
      automatic int r = int'($urandom_range(0, 99));
      automatic logic [31:0] ep = $urandom & 32'hFFFFFFFC;
      automatic logic [31:0] rt = $urandom & 32'hFFFFFFFC;
      step($urandom_range(0, 3) == 0, r < 2, r >= 1 && r < 4, ep, r >= 3 && r < 9, rt);
    end
    step(0, 0, 0, 0, 0, 0);
    check("progress", {31'd0, consumed > 300}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer for the pipelined MIPS CPU.
- Owns the PC register: drives its D and CE, reads back Q.
- Issues instruction-memory requests over a req/ack handshake and delivers fetched instructions into the IF/ID register.
- Arbitrates next-PC sources: sequential, branch/jump redirect, ERET, exception vector; honours hazard stalls and discards stale fetches after a redirect.

Parameters:
- RESET_VECTOR, 32'hBFC00000, boot address; must equal the PC register reset value.
- EXC_VECTOR, 32'hBFC00380, general exception entry.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- stall  input  1  hazard unit: hold IF/ID outputs
- exc_req  input  1  exception redirect, one-cycle pulse
- eret_req  input  1  ERET redirect, one-cycle pulse
- epc  input  32  ERET target
- redirect_valid  input  1  branch/jump taken, one-cycle pulse
- redirect_target  input  32  branch/jump target
- pc_q  input  32  current PC from PC register
- pc_d  output  32  next PC to PC register
- pc_ce  output  1  PC register load enable
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction
- if_valid  output  1  if_instr/if_pc hold a live instruction
- if_pc  output  32  PC of delivered instruction
- if_instr  output  32  delivered instruction

Behaviour:
- Reset (async):
  - state=BOOT
  - if_valid=0, if_instr=0, if_pc=RESET_VECTOR
  - skid buffer cleared, req_addr=RESET_VECTOR
  - Combinational outputs in BOOT: imem_req=0, pc_ce=0.
- States:
  - BOOT: no request. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc_q. pc_ce=0 unless ack or redirect, so the address stays stable while pending.
    - ack and !stall: if_valid<=1, if_instr<=imem_rdata, if_pc<=pc_q; pc_ce=1, pc_d=pc_q+4; stay FETCH. Zero-wait memory therefore sustains 1 instr/cycle.
    - ack and stall: skid<=imem_rdata, skid_pc<=pc_q; pc_ce=1, pc_d=pc_q+4; go HOLD; if_* unchanged.
  - HOLD: imem_req=0.
    - !stall: if_* <= skid contents, if_valid<=1; go FETCH.
  - FLUSH: imem_req=1, imem_addr=req_addr (the stale address). On ack, discard imem_rdata and go FETCH. if_valid stays 0.
- Redirect arbitration:
  - Priority exc_req > eret_req > redirect_valid.
  - Target = EXC_VECTOR / epc / redirect_target respectively.
- Any redirect, in any state, same cycle:
  - pc_ce=1, pc_d=target; if_valid<=0 next edge. Overrides stall and the ack-advance.
  - BOOT or HOLD: skid discarded; go FETCH.
  - FETCH with ack: data discarded; go FETCH.
  - FETCH without ack: req_addr<=pc_q; go FLUSH. The handshake must not drop an accepted request.
  - FLUSH without ack: PC reloaded, stay FLUSH; req_addr unchanged.
  - FLUSH with ack: go FETCH.
- Stall without redirect: if_valid, if_pc, if_instr hold their values; the PC advances at most one beyond the held instruction (skid depth 1).
- Arithmetic: pc_d=pc_q+4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000. No alignment checking in this block.
- pc_d when pc_ce=0: equals pc_q (don't-care for the register, but fixed for verification).
- imem_ack outside FETCH/FLUSH: protocol violation, ignored.
- Reset mid-operation: immediate return to BOOT. Any outstanding memory response arriving after reset is ignored (BOOT has no request).

Test Plan:
- Boot/sequential fetch: release rst; memory acks with zero wait. Cycle 1 imem_req=0. Then imem_addr=0xBFC00000; ack with data 0x24080001 gives if_valid=1, if_pc=0xBFC00000, if_instr=0x24080001. pc_q steps 0xBFC00004, 0xBFC00008 one per cycle.
- Stall on ack: stall=1 at ack for 0xBFC00004 (data 0x8C090000); hold stall 3 cycles. Expect if_* unchanged, imem_req=0, pc_q=0xBFC00008. After release, if_pc=0xBFC00004 delivered exactly once.
- Redirect with outstanding fetch: ack delayed 3 cycles; redirect_valid=1, target 0xBFC00100, in cycle 1 of the wait. Expect pc_q=0xBFC00100 and imem_addr held at the old PC until ack, with that data dropped (if_valid=0). Next request is at 0xBFC00100.
- Priority: exc_req, eret_req (epc=0x80001000) and redirect_valid all high with stall=1. Expect pc_q=0xBFC00380, if_valid=0. Later eret_req alone gives next fetch at 0x80001000.
- Wrap: redirect to 0xFFFFFFFC, ack, no stall. Expect if_pc=0xFFFFFFFC, next imem_addr=0x00000000.
- Async reset mid-FLUSH: assert rst between clock edges. Expect immediate if_valid=0, imem_req=0, if_pc=0xBFC00000; a late ack is ignored; fetch restarts at 0xBFC00000.
